rr_reg_arbiter: RTL and testbench

//   Round-robin arbiter sharing one WIDTH-bit register between NREQ requesters.

---
 rtl/rr_reg_arbiter.sv | 133 +++++++++++++
 tb/tb_rr_reg_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit register among NREQ requesters.
// Each tenure allows up to MAXHOLD writes; priority then moves past the owner.
module rr_reg_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int MAXHOLD = 4,
  parameter logic [WIDTH-1:0] RSTVAL = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy,
  output logic [WIDTH-1:0]         q,
  output logic                     q_upd
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAXHOLD + 1);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              q_upd_q, q_upd_d;

  logic [IW-1:0]     nxt_ptr;
  logic [IW-1:0]     start;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     pick;
  logic              hit;
  logic              rel;
  logic [CW-1:0]     cnt_inc;

  // Search start: the held pointer when idle, the slot after the owner on release
  always_comb begin
    nxt_ptr = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
    start   = (state_q == S_IDLE) ? ptr_q : nxt_ptr;
  end

  // First requester at or after start, wrapping, so the releasing owner comes last
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    idx  = start;
    for (int k = 0; k < NREQ; k++) begin
      if (!hit && req[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
      idx = (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);
    end
  end

  // Next-state, grant, tenure count and shared register update
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    q_upd_d = 1'b0;
    rel     = 1'b0;
    cnt_inc = cnt_q + CW'(1);
    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          state_d = S_OWN;
          gnt_d   = NREQ'(1) << pick;
          owner_d = pick;
          cnt_d   = '0;
        end else begin
          gnt_d = '0;
        end
      end
      S_OWN: begin
        rel = 1'b1;
        if (req[owner_q]) begin
          q_d     = wdata[owner_q*WIDTH +: WIDTH];
          q_upd_d = 1'b1;
          cnt_d   = cnt_inc;
          rel     = (cnt_inc == CW'(MAXHOLD));
        end
        if (rel) begin
          ptr_d = nxt_ptr;
          cnt_d = '0;
          if (hit) begin
            gnt_d   = NREQ'(1) << pick;
            owner_d = pick;
          end else begin
            state_d = S_IDLE;
            gnt_d   = '0;
          end
        end
      end
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      q_q     <= RSTVAL;
      q_upd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      q_upd_q <= q_upd_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = (state_q == S_OWN);
  assign q     = q_q;
  assign q_upd = q_upd_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Bench for rr_reg_arbiter: MAXHOLD=4 and MAXHOLD=1 instances share stimulus
// and are compared every cycle against a tenure-level reference model.
module tb_rr_reg_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;

  logic [3:0]  gnt_o   [2];
  logic [1:0]  owner_o [2];
  logic        busy_o  [2];
  logic [7:0]  q_o     [2];
  logic        upd_o   [2];

  int n_cmp;
  int n_bad;

  int m_busy  [2];
  int m_owner [2];
  int m_ptr   [2];
  int m_cnt   [2];
  int m_q     [2];
  int m_upd   [2];
  int mh      [2];

  rr_reg_arbiter #(.NREQ(4), .WIDTH(8), .MAXHOLD(4), .RSTVAL(8'h00)) u_a (
    .clock(clk), .reset(rst), .req(req), .wdata(wdata),
    .gnt(gnt_o[0]), .owner(owner_o[0]), .busy(busy_o[0]),
    .q(q_o[0]), .q_upd(upd_o[0])
  );

  rr_reg_arbiter #(.NREQ(4), .WIDTH(8), .MAXHOLD(1), .RSTVAL(8'h00)) u_b (
    .clock(clk), .reset(rst), .req(req), .wdata(wdata),
    .gnt(gnt_o[1]), .owner(owner_o[1]), .busy(busy_o[1]),
    .q(q_o[1]), .q_upd(upd_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_busy[m] = 0; m_owner[m] = 0; m_ptr[m] = 0;
      m_cnt[m] = 0; m_q[m] = 0; m_upd[m] = 0;
    end
  endtask

  task automatic model_edge();
    int j;
    bit release_now;
    for (int m = 0; m < 2; m++) begin
      m_upd[m] = 0;
      if (m_busy[m] == 0) begin
        j = first_from(req, m_ptr[m]);
        if (j >= 0) begin
          m_busy[m] = 1; m_owner[m] = j; m_cnt[m] = 0;
        end
      end else begin
        release_now = 1;
        if (req[m_owner[m]]) begin
          m_q[m] = (wdata >> (8 * m_owner[m])) & 'hff;
          m_upd[m] = 1;
          m_cnt[m]++;
          release_now = (m_cnt[m] == mh[m]);
        end
        if (release_now) begin
          m_ptr[m] = (m_owner[m] + 1) % 4;
          m_cnt[m] = 0;
          j = first_from(req, m_ptr[m]);
          if (j >= 0) m_owner[m] = j;
          else m_busy[m] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("gnt%0d", m), int'(gnt_o[m]),
          m_busy[m] != 0 ? (1 << m_owner[m]) : 0);
      chk($sformatf("owner%0d", m), int'(owner_o[m]), m_owner[m]);
      chk($sformatf("busy%0d", m), int'(busy_o[m]), m_busy[m]);
      chk($sformatf("q%0d", m), int'(q_o[m]), m_q[m]);
      chk($sformatf("upd%0d", m), int'(upd_o[m]), m_upd[m]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    #2;
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    mh[0] = 4;
    mh[1] = 1;
    rst   = 1'b1;
    req   = '0;
    wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;

    req   = 4'b0001;
    wdata = 32'h000000A5;
    repeat (12) step();

    req = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      wdata = $urandom;
      step();
    end

    req = 4'b0000;
    repeat (3) step();
    req = 4'b0100;
    wdata = 32'h00330000;
    repeat (3) step();
    async_reset();
    repeat (3) step();

    req = 4'b0000;
    repeat (2) step();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(3) == 0) req = 4'($urandom);
      wdata = $urandom;
      step();
      if ($urandom_range(199) == 0) async_reset();
    end

    req = 4'b0000;
    repeat (3) step();
    req   = 4'b0110;
    wdata = 32'h00221100;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
